// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // All controller outputs bundled so reset gating is one assignment.
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic [3:0] irwrite;
    logic       pcen;
    logic [1:0] pcsource;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic [2:0] alucontrol;
    logic       ill_op;
  } ctrl_out_t;

  // Instruction-register byte lane written by each fetch state.
  function automatic logic [3:0] fetch_byte_en(input state_t s);
    case (s)
      S_FETCH1: fetch_byte_en = 4'b0001;
      S_FETCH2: fetch_byte_en = 4'b0010;
      S_FETCH3: fetch_byte_en = 4'b0100;
      S_FETCH4: fetch_byte_en = 4'b1000;
      default:  fetch_byte_en = 4'b0000;
    endcase
  endfunction

  // Successor of each fetch state once its byte has arrived.
  function automatic state_t fetch_next(input state_t s);
    case (s)
      S_FETCH1: fetch_next = S_FETCH2;
      S_FETCH2: fetch_next = S_FETCH3;
      S_FETCH3: fetch_next = S_FETCH4;
      default:  fetch_next = S_DECODE;
    endcase
  endfunction

endpackage

// File: rtl/mips_controller_if.sv
// Controller <-> datapath/memory signal bundle.
interface mips_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       memread;
  logic       memwrite;
  logic       iord;
  logic [3:0] irwrite;
  logic       pcen;
  logic [1:0] pcsource;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic [2:0] alucontrol;
  logic       ill_op;

  modport master (
    input  op, funct, zero, mem_ready,
    output memread, memwrite, iord, irwrite, pcen, pcsource, alusrca,
           alusrcb, regwrite, regdst, memtoreg, alucontrol, ill_op
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  memread, memwrite, iord, irwrite, pcen, pcsource, alusrca,
           alusrcb, regwrite, regdst, memtoreg, alucontrol, ill_op
  );
endinterface

// File: rtl/mips_controller_alu_decoder.sv
// Combinational aluop/funct to ALU control decode.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol,
  output logic       o_ill_funct
);

  // Unknown funct falls back to ADD and raises the illegal flag.
  always_comb begin
    o_alucontrol = ALU_ADD;
    o_ill_funct  = 1'b0;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FUNCT_ADD: o_alucontrol = ALU_ADD;
          FUNCT_SUB: o_alucontrol = ALU_SUB;
          FUNCT_AND: o_alucontrol = ALU_AND;
          FUNCT_OR:  o_alucontrol = ALU_OR;
          FUNCT_SLT: o_alucontrol = ALU_SLT;
          default: begin
            o_alucontrol = ALU_ADD;
            o_ill_funct  = 1'b1;
          end
        endcase
      end
      default: o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM with byte-wise fetch and memory stall handshake.
module mips_controller
  import mips_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  mips_controller_if.master bus
);

  state_t     r_state;
  state_t     w_state_next;
  ctrl_out_t  w_dec;
  ctrl_out_t  w_out;
  logic [1:0] w_aluop;
  logic       w_alu_used;
  logic       w_pcwrite;
  logic       w_branch;
  logic [2:0] w_alucontrol;
  logic       w_ill_funct;

  alu_decoder u_alu_decoder (
    .i_aluop      (w_aluop),
    .i_funct      (bus.funct),
    .o_alucontrol (w_alucontrol),
    .o_ill_funct  (w_ill_funct)
  );

  // State register; reset aborts any instruction and returns to FETCH1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH1;
    else          r_state <= w_state_next;
  end

  // Next-state and output decode from the current state and live inputs.
  always_comb begin
    w_state_next = r_state;
    w_dec        = '0;
    w_aluop      = ALUOP_ADD;
    w_alu_used   = 1'b0;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;

    case (r_state)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        w_dec.memread  = 1'b1;
        w_dec.alusrcb  = SRCB_ONE;
        w_dec.pcsource = PCSRC_ALU;
        w_alu_used     = 1'b1;
        if (bus.mem_ready) begin
          w_dec.irwrite = fetch_byte_en(r_state);
          w_pcwrite     = 1'b1;
          w_state_next  = fetch_next(r_state);
        end
      end
      S_DECODE: begin
        w_dec.alusrcb = SRCB_BOFF;
        w_alu_used    = 1'b1;
        case (bus.op)
          OP_LB, OP_SB: w_state_next = S_MEMADR;
          OP_RTYPE:     w_state_next = S_RTYPEEX;
          OP_BEQ:       w_state_next = S_BEQEX;
          OP_J:         w_state_next = S_JEX;
          OP_ADDI:      w_state_next = S_ADDIEX;
          default: begin
            w_dec.ill_op = 1'b1;
            w_state_next = S_FETCH1;
          end
        endcase
      end
      S_MEMADR: begin
        w_dec.alusrca = 1'b1;
        w_dec.alusrcb = SRCB_IMM;
        w_alu_used    = 1'b1;
        w_state_next  = (bus.op == OP_SB) ? S_SBWR : S_LBRD;
      end
      S_LBRD: begin
        w_dec.memread = 1'b1;
        w_dec.iord    = 1'b1;
        if (bus.mem_ready) w_state_next = S_LBWR;
      end
      S_LBWR: begin
        w_dec.regwrite = 1'b1;
        w_dec.memtoreg = 1'b1;
        w_state_next   = S_FETCH1;
      end
      S_SBWR: begin
        w_dec.memwrite = 1'b1;
        w_dec.iord     = 1'b1;
        if (bus.mem_ready) w_state_next = S_FETCH1;
      end
      S_RTYPEEX: begin
        w_dec.alusrca = 1'b1;
        w_dec.alusrcb = SRCB_REGB;
        w_aluop       = ALUOP_FUNCT;
        w_alu_used    = 1'b1;
        if (w_ill_funct) begin
          w_dec.ill_op = 1'b1;
          w_state_next = S_FETCH1;
        end else begin
          w_state_next = S_RTYPEWR;
        end
      end
      S_RTYPEWR: begin
        w_dec.regwrite = 1'b1;
        w_dec.regdst   = 1'b1;
        w_state_next   = S_FETCH1;
      end
      S_BEQEX: begin
        w_dec.alusrca  = 1'b1;
        w_dec.alusrcb  = SRCB_REGB;
        w_dec.pcsource = PCSRC_ALUOUT;
        w_aluop        = ALUOP_SUB;
        w_alu_used     = 1'b1;
        w_branch       = 1'b1;
        w_state_next   = S_FETCH1;
      end
      S_JEX: begin
        w_pcwrite      = 1'b1;
        w_dec.pcsource = PCSRC_JUMP;
        w_state_next   = S_FETCH1;
      end
      S_ADDIEX: begin
        w_dec.alusrca = 1'b1;
        w_dec.alusrcb = SRCB_IMM;
        w_alu_used    = 1'b1;
        w_state_next  = S_ADDIWR;
      end
      S_ADDIWR: begin
        w_dec.regwrite = 1'b1;
        w_state_next   = S_FETCH1;
      end
      default: w_state_next = S_FETCH1;
    endcase

    w_dec.pcen       = w_pcwrite | (w_branch & bus.zero);
    w_dec.alucontrol = w_alu_used ? w_alucontrol : ALU_AND;
  end

  // Outputs are held at zero for the whole time reset is asserted.
  assign w_out = reset_n ? w_dec : '0;

  assign bus.memread    = w_out.memread;
  assign bus.memwrite   = w_out.memwrite;
  assign bus.iord       = w_out.iord;
  assign bus.irwrite    = w_out.irwrite;
  assign bus.pcen       = w_out.pcen;
  assign bus.pcsource   = w_out.pcsource;
  assign bus.alusrca    = w_out.alusrca;
  assign bus.alusrcb    = w_out.alusrcb;
  assign bus.regwrite   = w_out.regwrite;
  assign bus.regdst     = w_out.regdst;
  assign bus.memtoreg   = w_out.memtoreg;
  assign bus.alucontrol = w_out.alucontrol;
  assign bus.ill_op     = w_out.ill_op;

endmodule
